// File: rtl/wb_stage_pkg.sv
// Shared definitions for wb_stage: FSM state and load-op encodings.
package wb_stage_pkg;

  localparam int unsigned LDOP_W = 3;
  localparam int unsigned PC_W   = 32;

  // Writeback FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } wb_state_e;

  // Load-op encodings
  localparam logic [LDOP_W-1:0] LD_LB  = 3'd0;
  localparam logic [LDOP_W-1:0] LD_LBU = 3'd1;
  localparam logic [LDOP_W-1:0] LD_LH  = 3'd2;
  localparam logic [LDOP_W-1:0] LD_LHU = 3'd3;
  localparam logic [LDOP_W-1:0] LD_LW  = 3'd4;

endpackage

// File: rtl/wb_stage_if.sv
// Writeback stage bus: upstream transaction, memory return, flush and register-file write.
// Optional debug trace signals exist only when WB_DEBUG_TRACE_EN is defined.
interface wb_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  import wb_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_wreg;
  logic [ADDR_W-1:0] in_wd;
  logic [DATA_W-1:0] in_wdata;
  logic              in_load;
  logic [LDOP_W-1:0] in_ldop;
  logic [PC_W-1:0]   in_pc;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
`ifdef WB_DEBUG_TRACE_EN
  logic [PC_W-1:0]   debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [ADDR_W-1:0] debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;
`endif

  // Upstream / environment side
  modport master (
    output in_valid, in_wreg, in_wd, in_wdata, in_load, in_ldop, in_pc,
    output mem_rvalid, mem_rdata, flush,
`ifdef WB_DEBUG_TRACE_EN
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
`endif
    input  in_ready, we, waddr, wdata
  );

  // wb_stage side
  modport slave (
    input  in_valid, in_wreg, in_wd, in_wdata, in_load, in_ldop, in_pc,
    input  mem_rvalid, mem_rdata, flush,
`ifdef WB_DEBUG_TRACE_EN
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
`endif
    output in_ready, we, waddr, wdata
  );

endinterface

// File: rtl/wb_stage_load_ext.sv
// Little-endian byte/half/word extraction with sign or zero extension.
module load_ext
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [LDOP_W-1:0] ldop,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select lane by address and extend per load type
  always_comb begin
    w_byte = 8'(word >> {addr, 3'b000});
    w_half = 16'(word >> {addr[1], 4'b0000});
    result = word;
    case (ldop)
      LD_LB:   result = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_LBU:  result = {{(DATA_W-8){1'b0}}, w_byte};
      LD_LH:   result = {{(DATA_W-16){w_half[15]}}, w_half};
      LD_LHU:  result = {{(DATA_W-16){1'b0}}, w_half};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts ALU/load results, waits for load data, commits one register write.
// Interface widths must match DATA_W/ADDR_W. WB_DEBUG_TRACE_EN adds the debug trace outputs.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic   clk,
  input  logic   rst,
  wb_stage_if.slave bus
);

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;

  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              r_wreg;
  logic [ADDR_W-1:0] r_wd;
  logic [1:0]        r_addr;
  logic [LDOP_W-1:0] r_ldop;

  logic              w_can_accept;
  logic              w_accept;
  logic              w_cap;
  logic              w_ready_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_waddr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic [DATA_W-1:0] w_ld_result;

`ifdef WB_DEBUG_TRACE_EN
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_dbg_pc;
  logic [PC_W-1:0]   w_dbg_pc_nxt;
`endif

  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_COMMIT);
  assign w_accept     = bus.in_valid && w_can_accept && !bus.flush;

  load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .ldop   (r_ldop),
    .addr   (r_addr),
    .word   (bus.mem_rdata),
    .result (w_ld_result)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_COMMIT: begin
        if (w_accept) w_state_nxt = bus.in_load ? ST_WAIT : ST_COMMIT;
        else          w_state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (bus.flush)           w_state_nxt = bus.mem_rvalid ? ST_IDLE : ST_DRAIN;
        else if (bus.mem_rvalid) w_state_nxt = ST_COMMIT;
      end
      ST_DRAIN: begin
        if (bus.mem_rvalid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered write port and capture strobe
  always_comb begin
    w_cap       = 1'b0;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = '0;
    w_wdata_nxt = '0;
    w_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_COMMIT);
`ifdef WB_DEBUG_TRACE_EN
    w_dbg_pc_nxt = '0;
`endif
    case (r_state)
      ST_IDLE, ST_COMMIT: begin
        if (w_accept) begin
          w_cap = 1'b1;
          if (!bus.in_load) begin
            w_we_nxt    = bus.in_wreg && (bus.in_wd != '0);
            w_waddr_nxt = bus.in_wd;
            w_wdata_nxt = bus.in_wdata;
`ifdef WB_DEBUG_TRACE_EN
            w_dbg_pc_nxt = bus.in_pc;
`endif
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid && !bus.flush) begin
          w_we_nxt    = r_wreg && (r_wd != '0);
          w_waddr_nxt = r_wd;
          w_wdata_nxt = w_ld_result;
`ifdef WB_DEBUG_TRACE_EN
          w_dbg_pc_nxt = r_pc;
`endif
        end
      end
      default: ;
    endcase
  end

  // Registered write port and ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_ready <= w_ready_nxt;
      r_we    <= w_we_nxt;
      r_waddr <= w_waddr_nxt;
      r_wdata <= w_wdata_nxt;
    end
  end

  // Transaction capture on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wreg <= 1'b0;
      r_wd   <= '0;
      r_addr <= '0;
      r_ldop <= '0;
    end else if (w_cap) begin
      r_wreg <= bus.in_wreg;
      r_wd   <= bus.in_wd;
      r_addr <= bus.in_wdata[1:0];
      r_ldop <= bus.in_ldop;
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  // PC capture and registered trace pc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= '0;
      r_dbg_pc <= '0;
    end else begin
      if (w_cap) r_pc <= bus.in_pc;
      r_dbg_pc <= w_dbg_pc_nxt;
    end
  end

  assign bus.debug_wb_pc       = r_dbg_pc;
  assign bus.debug_wb_rf_wen   = {4{r_we}};
  assign bus.debug_wb_rf_wnum  = r_waddr;
  assign bus.debug_wb_rf_wdata = r_wdata;
`endif

  assign bus.in_ready = r_ready;
  assign bus.we       = r_we;
  assign bus.waddr    = r_waddr;
  assign bus.wdata    = r_wdata;

endmodule
